// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-configurable serial bit-pattern detector with saturating hit counter
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b1010),
  parameter logic [LEN_W-1:0]   RST_LEN     = LEN_W'(4),
  parameter logic               RST_OVERLAP = 1'b1,
  parameter logic               RST_MEALY   = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_mealy,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic               mealy;
  logic               match_q;

  logic [LEN_W-1:0]   le;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] window;
  logic               hit;

  // Effective length, compare mask and combinational hit; the window is the
  // history as it will look after shifting in the current bit.
  always_comb begin
    le     = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(le));
    end
    window = {hist[MAX_LEN-2:0], in_bit};
    hit    = in_valid && !clr && !cfg_we && (le != '0) &&
             (fill >= (le - LEN_W'(1))) &&
             ((window & mask) == (pat & mask));
  end

  // Mealy forwards the hit directly; Moore shows it one cycle later.
  assign match = mealy ? hit : match_q;

  // History, fill, configuration, registered match and hit counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist        <= '0;
      fill        <= '0;
      match_q     <= 1'b0;
      match_count <= '0;
      pat         <= RST_PATTERN;
      len         <= RST_LEN;
      ovl         <= RST_OVERLAP;
      mealy       <= RST_MEALY;
    end else if (clr) begin
      hist        <= '0;
      fill        <= '0;
      match_q     <= 1'b0;
      match_count <= '0;
    end else if (cfg_we) begin
      // New configuration starts a fresh stream; the bit on in_bit is dropped
      // and any pending Moore match is cancelled.
      pat     <= cfg_pattern;
      len     <= cfg_len;
      ovl     <= cfg_overlap;
      mealy   <= cfg_mealy;
      hist    <= '0;
      fill    <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (in_valid) begin
        hist <= window;
        if (hit && !ovl) begin
          // Non-overlapping: the completing bit is consumed, restart the fill.
          fill <= '0;
        end else if (fill != LEN_W'(MAX_LEN)) begin
          fill <= fill + LEN_W'(1);
        end
      end
      if (hit && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - table-driven self-checking bench for seq_detect_param
module tb_seq_detect_param;

  logic       clk;
  logic       rstn;

  logic       clr1, cfg1, ovl1, mealy1, v1, b1;
  logic [7:0] pat1;
  logic [3:0] len1;
  logic       m1;
  logic [7:0] cnt1;
  logic [3:0] fill1;

  logic       clr2, cfg2, ovl2, mealy2, v2, b2;
  logic [7:0] pat2;
  logic [3:0] len2;
  logic       m2;
  logic [1:0] cnt2;
  logic [3:0] fill2;

  int checks;
  int errors;

  seq_detect_param dut (
    .clk(clk), .rstn(rstn), .clr(clr1), .cfg_we(cfg1),
    .cfg_pattern(pat1), .cfg_len(len1), .cfg_overlap(ovl1), .cfg_mealy(mealy1),
    .in_valid(v1), .in_bit(b1),
    .match(m1), .match_count(cnt1), .fill(fill1)
  );

  seq_detect_param #(.CNT_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .clr(clr2), .cfg_we(cfg2),
    .cfg_pattern(pat2), .cfg_len(len2), .cfg_overlap(ovl2), .cfg_mealy(mealy2),
    .in_valid(v2), .in_bit(b2),
    .match(m2), .match_count(cnt2), .fill(fill2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       clr;
    logic       cfg;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       mealy;
    logic       v;
    logic       b;
    logic       m;
    int         cnt;
    int         fill;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk_bit(logic v, logic b, logic m, int cnt, int fill);
    vec_t r;
    r = '0;
    r.v = v; r.b = b; r.m = m; r.cnt = cnt; r.fill = fill;
    return r;
  endfunction

  function automatic vec_t mk_cfg(logic [7:0] pat, logic [3:0] len, logic ovl, logic mealy,
                                  logic m, int cnt);
    vec_t r;
    r = '0;
    r.cfg = 1'b1; r.pat = pat; r.len = len; r.ovl = ovl; r.mealy = mealy;
    r.v = 1'b1; r.b = 1'b1; r.m = m; r.cnt = cnt; r.fill = 0;
    return r;
  endfunction

  function automatic vec_t mk_clr(logic m);
    vec_t r;
    r = '0;
    r.clr = 1'b1; r.m = m; r.cnt = 0; r.fill = 0;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus on instance d (0 = main, 1 = CNT_W=2 instance).
  task automatic drive(input int d, input vec_t r, input string tag);
    @(negedge clk);
    if (d == 0) begin
      clr1 = r.clr; cfg1 = r.cfg; pat1 = r.pat; len1 = r.len;
      ovl1 = r.ovl; mealy1 = r.mealy; v1 = r.v; b1 = r.b;
    end else begin
      clr2 = r.clr; cfg2 = r.cfg; pat2 = r.pat; len2 = r.len;
      ovl2 = r.ovl; mealy2 = r.mealy; v2 = r.v; b2 = r.b;
    end
    #2;
    check({tag, " match"}, int'(d == 0 ? m1 : m2), int'(r.m));
    @(posedge clk);
    #1;
    check({tag, " count"}, (d == 0) ? int'(cnt1) : int'(cnt2), r.cnt);
    if (r.fill >= 0)
      check({tag, " fill"}, (d == 0) ? int'(fill1) : int'(fill2), r.fill);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    {clr1, cfg1, ovl1, mealy1, v1, b1} = '0; pat1 = '0; len1 = '0;
    {clr2, cfg2, ovl2, mealy2, v2, b2} = '0; pat2 = '0; len2 = '0;

    // Default config, overlapping 1010 Mealy
    tv.push_back(mk_bit(1, 1, 0, 0, 1));
    tv.push_back(mk_bit(1, 0, 0, 0, 2));
    tv.push_back(mk_bit(1, 1, 0, 0, 3));
    tv.push_back(mk_bit(1, 0, 1, 1, 4));
    tv.push_back(mk_bit(1, 1, 0, 1, 5));
    tv.push_back(mk_bit(1, 0, 1, 2, 6));
    tv.push_back(mk_bit(1, 1, 0, 2, 7));
    // Non-overlapping 1010
    tv.push_back(mk_clr(0));
    tv.push_back(mk_cfg(8'h0A, 4, 0, 1, 0, 0));
    tv.push_back(mk_bit(1, 1, 0, 0, 1));
    tv.push_back(mk_bit(1, 0, 0, 0, 2));
    tv.push_back(mk_bit(1, 1, 0, 0, 3));
    tv.push_back(mk_bit(1, 0, 1, 1, 0));
    tv.push_back(mk_bit(1, 1, 0, 1, 1));
    tv.push_back(mk_bit(1, 0, 0, 1, 2));
    tv.push_back(mk_bit(1, 1, 0, 1, 3));
    // Moore 111, overlapping
    tv.push_back(mk_clr(0));
    tv.push_back(mk_cfg(8'h07, 3, 1, 0, 0, 0));
    tv.push_back(mk_bit(1, 1, 0, 0, 1));
    tv.push_back(mk_bit(1, 1, 0, 0, 2));
    tv.push_back(mk_bit(1, 1, 0, 1, 3));
    tv.push_back(mk_bit(1, 1, 1, 2, 4));
    tv.push_back(mk_bit(1, 1, 1, 3, 5));
    tv.push_back(mk_bit(0, 0, 1, 3, 5));
    tv.push_back(mk_bit(0, 0, 0, 3, 5));
    // Moore 111, non-overlapping, then cfg while a Moore match is pending
    tv.push_back(mk_clr(0));
    tv.push_back(mk_cfg(8'h07, 3, 0, 0, 0, 0));
    tv.push_back(mk_bit(1, 1, 0, 0, 1));
    tv.push_back(mk_bit(1, 1, 0, 0, 2));
    tv.push_back(mk_bit(1, 1, 0, 1, 0));
    tv.push_back(mk_bit(1, 1, 1, 1, 1));
    tv.push_back(mk_bit(1, 1, 0, 1, 2));
    tv.push_back(mk_bit(0, 0, 0, 1, 2));
    tv.push_back(mk_bit(1, 1, 0, 2, 0));
    tv.push_back(mk_cfg(8'h07, 3, 1, 1, 1, 2));
    tv.push_back(mk_bit(0, 0, 0, 2, 0));
    // MAX_LEN pattern with a 3-cycle valid gap
    tv.push_back(mk_clr(0));
    tv.push_back(mk_cfg(8'hCA, 8, 1, 1, 0, 0));
    tv.push_back(mk_bit(1, 1, 0, 0, 1));
    tv.push_back(mk_bit(1, 1, 0, 0, 2));
    tv.push_back(mk_bit(1, 0, 0, 0, 3));
    tv.push_back(mk_bit(1, 0, 0, 0, 4));
    tv.push_back(mk_bit(0, 1, 0, 0, 4));
    tv.push_back(mk_bit(0, 1, 0, 0, 4));
    tv.push_back(mk_bit(0, 1, 0, 0, 4));
    tv.push_back(mk_bit(1, 1, 0, 0, 5));
    tv.push_back(mk_bit(1, 0, 0, 0, 6));
    tv.push_back(mk_bit(1, 1, 0, 0, 7));
    tv.push_back(mk_bit(1, 0, 1, 1, 8));
    // len = 0 disables detection, count is retained across cfg
    tv.push_back(mk_cfg(8'h00, 0, 1, 1, 0, 1));
    tv.push_back(mk_bit(1, 0, 0, 1, 1));
    tv.push_back(mk_bit(1, 0, 0, 1, 2));

    // Reset state
    #12;
    check("reset match", int'(m1), 0);
    check("reset count", int'(cnt1), 0);
    check("reset fill", int'(fill1), 0);
    check("reset count sat", int'(cnt2), 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(0, tv[i], $sformatf("vec%0d", i));
    end

    // Async reset mid-pattern with default pattern
    drive(0, mk_cfg(8'h0A, 4, 1, 1, 0, 1), "ar cfg");
    drive(0, mk_bit(1, 1, 0, 1, 1), "ar b1");
    drive(0, mk_bit(1, 0, 0, 1, 2), "ar b2");
    drive(0, mk_bit(1, 1, 0, 1, 3), "ar b3");
    v1 = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    check("ar async count", int'(cnt1), 0);
    check("ar async fill", int'(fill1), 0);
    check("ar async match", int'(m1), 0);
    #1;
    rstn = 1'b1;
    drive(0, mk_bit(1, 0, 0, 0, 1), "ar p0");
    drive(0, mk_bit(1, 1, 0, 0, 2), "ar p1");
    drive(0, mk_bit(1, 0, 0, 0, 3), "ar p2");
    drive(0, mk_bit(1, 1, 0, 0, 4), "ar p3");
    drive(0, mk_bit(1, 0, 1, 1, 5), "ar p4");

    // Saturation with CNT_W=2, then clr on a would-be hit
    drive(1, mk_cfg(8'h01, 1, 1, 1, 0, 0), "sat cfg");
    drive(1, mk_bit(1, 1, 1, 1, -1), "sat 1");
    drive(1, mk_bit(1, 1, 1, 2, -1), "sat 2");
    drive(1, mk_bit(1, 1, 1, 3, -1), "sat 3");
    drive(1, mk_bit(1, 1, 1, 3, -1), "sat 4");
    drive(1, mk_bit(1, 1, 1, 3, -1), "sat 5");
    begin
      vec_t r;
      r = mk_clr(0);
      r.v = 1'b1;
      r.b = 1'b1;
      drive(1, r, "sat clr");
    end
    drive(1, mk_bit(1, 1, 1, 1, 1), "sat after clr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
